// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the RV32I immediate encoder and sign-extender.
// Holds the format enum, field bit positions and a signed-range helper.
package imm_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_U = 2'b11
    } imm_src_t;

    // I-type: instr[31:20]
    localparam int I_MSB    = 31;
    localparam int I_LSB    = 20;
    // S-type: instr[31:25] / instr[11:7]
    localparam int S_HI_MSB = 31;
    localparam int S_HI_LSB = 25;
    localparam int S_LO_MSB = 11;
    localparam int S_LO_LSB = 7;
    // B-type: sign at 31, imm[11] at 7, imm[10:5] at 30:25, imm[4:1] at 11:8
    localparam int B_SIGN   = 31;
    localparam int B_BIT11  = 7;
    localparam int B_HI_MSB = 30;
    localparam int B_HI_LSB = 25;
    localparam int B_LO_MSB = 11;
    localparam int B_LO_LSB = 8;
    // U-type: instr[31:12]
    localparam int U_MSB    = 31;
    localparam int U_LSB    = 12;

    localparam int I_BITS   = 12;
    localparam int B_BITS   = 13;

    // True when v is a sign extension of its low nbits bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (nbits - 1));
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: overwrites the immediate fields of an instruction template.
// U-type packing on format 11 is enabled by IMM_ENCODER_UTYPE_EN; otherwise format 11 is an error.
module imm_pack
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  imm_src_t              imm_src,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  err
);

    always_comb begin
        instr_out = instr;
        err       = 1'b0;
        case (imm_src)
            IMM_I: begin
                instr_out[I_MSB:I_LSB] = imm[11:0];
                err = !fits_signed(imm, I_BITS);
            end
            IMM_S: begin
                instr_out[S_HI_MSB:S_HI_LSB] = imm[11:5];
                instr_out[S_LO_MSB:S_LO_LSB] = imm[4:0];
                err = !fits_signed(imm, I_BITS);
            end
            IMM_B: begin
                instr_out[B_SIGN]            = imm[12];
                instr_out[B_BIT11]           = imm[11];
                instr_out[B_HI_MSB:B_HI_LSB] = imm[10:5];
                instr_out[B_LO_MSB:B_LO_LSB] = imm[4:1];
                // branch offsets are halfword aligned, so bit 0 has no slot
                err = !fits_signed(imm, B_BITS) || imm[0];
            end
            IMM_U: begin
`ifdef IMM_ENCODER_UTYPE_EN
                instr_out[U_MSB:U_LSB] = imm[31:12];
                err = |imm[11:0];
`else
                err = 1'b1;
`endif
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Valid/ready immediate encoder with one output register stage and saturating error stats.
// Format 11 behaviour depends on IMM_ENCODER_UTYPE_EN (see imm_pack).
module imm_encoder
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_imm_src,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     err_sticky
);

    logic                     out_valid_q,  out_valid_d;
    logic [DATA_WIDTH-1:0]    out_instr_q,  out_instr_d;
    logic                     out_err_q,    out_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_count_q,  err_count_d;
    logic                     err_sticky_q, err_sticky_d;

    logic                  accept;
    logic [DATA_WIDTH-1:0] pack_instr;
    logic                  pack_err;

    imm_pack #(.DATA_WIDTH(DATA_WIDTH)) u_pack (
        .imm_src   (imm_src_t'(in_imm_src)),
        .imm       (in_imm),
        .instr     (in_instr),
        .instr_out (pack_instr),
        .err       (pack_err)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_err_d    = out_err_q;
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_instr;
            out_err_d   = pack_err;
            if (pack_err) begin
                err_sticky_d = 1'b1;
                if (err_count_q != '1)
                    err_count_d = err_count_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_err_q    <= 1'b0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_err_q    <= out_err_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_err    = out_err_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the control unit's immediate sign-extender: packs a 32-bit immediate into the bit positions of an RV32I instruction word for a given immediate format.
- Used by the instruction-memory loader and self-checking benches to build instruction words from (format, template, immediate).
- Valid/ready streaming block with one output register stage.
- Flags immediates that the chosen format cannot represent.

Parameters:
- DATA_WIDTH, 32, width of immediate input and instruction word; only 32 is supported.
- ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept request
- in_imm_src  input  2  format: 00 I-type, 01 S-type (sw), 10 B-type (beq), 11 U-type (optional)
- in_imm  input  DATA_WIDTH  sign-extended immediate value
- in_instr  input  DATA_WIDTH  template word; non-immediate fields (opcode/rd/rs/funct) are passed through
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  DATA_WIDTH  encoded instruction
- out_err  output  1  immediate not representable; qualified by out_valid
- err_count  output  ERR_CNT_WIDTH  saturating count of accepted erroneous requests
- err_sticky  output  1  set on first accepted erroneous request

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_instr=0, out_err=0, err_count=0, err_sticky=0. Reset mid-transfer drops any held word.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready; out_* load on that edge, giving 1-cycle latency.
  - out_valid clears when out_ready is high and no new accept occurs.
  - Back-to-back accepts give full throughput.
  - out_* hold stable while out_valid && !out_ready.
- Encoding: start from in_instr and overwrite only the immediate positions.
  - I (00): instr[31:20]=imm[11:0]. Error if imm[31:11] not all equal.
  - S (01): instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]. Error if imm[31:11] not all equal.
  - B (10): instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]. Error if imm[31:12] not all equal or imm[0]=1.
  - 11 without the optional feature: out_instr=in_instr, out_err=1.
- On error the word is still emitted with the truncated bits; out_err=1.
- err_count increments once per accepted erroneous request and saturates at all-ones; it does not wrap.
- err_sticky is cleared only by reset.
- Boundary immediates:
  - I/S: -2048 and 2047 are legal; 2048 is an error.
  - B: -4096 and 4094 are legal; 4096 is an error; any odd value is an error.
- Round-trip property: for every legal request, the sign-extender applied to out_instr (same format) returns in_imm.

Optional Feature:
- Macro IMM_ENCODER_UTYPE_EN.
- Defined: format 11 is U-type. instr[31:12]=imm[31:12]. Error if imm[11:0]!=0.
- Undefined: format 11 is always an error and passes in_instr unchanged, as described in Behaviour.

Decomposition:
- Shared package (imm_pkg): imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_U) and the field bit-position localparams, shared with the sign-extender.
- Combinational sub-module imm_pack: (imm_src, imm, instr) -> (instr_out, err).
- Top level holds the output register, handshake, and error counters.

Test Plan:
- I-type: template 0x00000013, imm=-1 (0xFFFFFFFF), out_ready=1 -> next cycle out_instr=0xFFF00013, out_err=0.
- S-type: template 0x00002023, imm=0x7FF -> out_instr=0x7E002FA3. Then imm=0x800 -> out_err=1, err_count=1, err_sticky=1.
- B-type: template 0x00000063, imm=-4096 (0xFFFFF000) -> out_instr=0x80000063. Then imm=5 -> out_err=1 (odd).
- Backpressure: hold out_ready=0 with two requests queued -> in_ready=0 after the first accept; out_instr stable. Release -> second word emitted the following cycle with no loss or duplication.
- Saturation and reset: 300 erroneous accepts -> err_count=255. Assert rst_n=0 mid-stream -> all outputs 0 immediately.
- Format 11, imm=0x12345000, template 0x00000037:
  - With IMM_ENCODER_UTYPE_EN -> out_instr=0x12345037, out_err=0.
  - Without it -> out_instr=0x00000037, out_err=1.
